resp_tx_arbiter: RTL and testbench
==================================

Name: resp_tx_arbiter

Overview:
Shares the single UART transmitter (trmt / tx_data / tx_done) between two response sources.
- Command acknowledge path: 1-byte responses, high priority.
- Telemetry path: multi-byte packets, low priority, protected from starvation.

The block sits between the command-processing logic and the UART_comm transmit side. It serialises packets MSB-byte-first and never interleaves bytes from different packets.

Parameters:
TLM_BYTES, 8, number of bytes per telemetry packet (2..8).
STARVE_LIM, 4, consecutive ack grants allowed while tlm_req is pending before telemetry is forced to win.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ack_req  input  1  acknowledge byte pending; level, held until ack_gnt
ack_byte  input  8  acknowledge byte; sampled only in the grant cycle
ack_gnt  output  1  one-cycle pulse: ack_byte captured, requester may drop or change ack_req/ack_byte
tlm_req  input  1  telemetry packet pending; level, held until tlm_gnt
tlm_data  input  64  packet, byte 0 at [63:56]; only the upper TLM_BYTES*8 bits are used; sampled only in the grant cycle
tlm_gnt  output  1  one-cycle pulse: tlm_data captured
trmt  output  1  one-cycle start pulse to the UART transmitter
tx_data  output  8  byte to transmit; stable from the trmt cycle until the matching tx_done
tx_done  input  1  UART transmit-complete level; drops the cycle after trmt, rises when the frame is complete
busy  output  1  high whenever state != IDLE
owner  output  1  0 = ack owns the transmitter, 1 = telemetry; valid while busy

Behaviour:
- Clock, reset and registers
  - Single clock, clk.
  - rst_n is asynchronous and active-low; every flop clears immediately when it asserts.
- Reset values
  - state = IDLE; trmt, ack_gnt, tlm_gnt, busy, owner = 0.
  - tx_data = 8'h00; shift register = 0; bytes_left = 0; starve_cnt = 0.
- Registered outputs: trmt, ack_gnt, tlm_gnt and tx_data are driven from flops. busy and owner are decoded from registered state.
- State machine: IDLE, SEND, WAIT.
- IDLE, arbitration at each clock edge:
  - force_tlm = tlm_req && (starve_cnt == STARVE_LIM).
  - If ack_req && !force_tlm: load shift reg with ack_byte; bytes_left = 1; owner = 0; ack_gnt = 1; trmt = 1. starve_cnt increments (saturating at STARVE_LIM) if tlm_req, else clears to 0.
  - Else if tlm_req: load shift reg with tlm_data; bytes_left = TLM_BYTES; owner = 1; tlm_gnt = 1; trmt = 1; starve_cnt = 0.
  - Either grant goes to SEND. With no request, stay in IDLE.
- Timing from a request:
  - Grant pulse and first trmt appear in the cycle after the request is first sampled in IDLE.
  - tx_data = shift reg [MSB byte] in that same cycle.
- SEND: lasts exactly one cycle (trmt high); next state is WAIT. trmt and gnt deassert.
- WAIT:
  - tx_done is ignored until it has been observed low at least once since trmt. This guards against a stale high level.
  - On the qualified rising tx_done with bytes_left == 1: go to IDLE.
  - On the qualified rising tx_done with bytes_left > 1: shift the register left by 8, decrement bytes_left, go to SEND (next byte's trmt one cycle after tx_done is seen).
- Throughput: back-to-back packets are allowed. After the last tx_done, IDLE arbitrates on the next edge, so there is a one-cycle IDLE gap between packets.
- Packet atomicity: a telemetry packet is never pre-empted. An ack_req arriving mid-packet waits until the packet completes.
- Simultaneous ack_req and tlm_req: ack wins unless starve_cnt == STARVE_LIM.
- Requests that drop before their grant are lost silently; no error is flagged.
- Input changes after the grant have no effect on the byte stream.
- Reset mid-packet: outputs return to their reset values immediately, the remaining bytes are discarded, and no grant is re-issued.

Test Plan:
- Reset, then ack_req=1 with ack_byte=8'hA5 → next cycle ack_gnt=1, trmt=1, tx_data=A5. After the model's tx_done: busy=0 and exactly 1 trmt counted.
- tlm_req with tlm_data=64'h0102030405060708, TLM_BYTES=8 → tlm_gnt once, 8 trmt pulses, tx_data sequence 01..08, owner=1 throughout.
- ack_req raised during byte 3 of a telemetry packet → the remaining bytes 04..08 finish first, then ack_gnt one cycle after busy falls. Ack byte is sent 9th.
- ack_req and tlm_req both held high continuously, STARVE_LIM=4 → grant order ack,ack,ack,ack,tlm,ack,... repeating.
- rst_n asserted during byte 5 of a packet → trmt/busy/owner/tx_data read 0 without waiting for a clock edge. After release with no requests: no trmt for 100 cycles.
- tx_done held high from before trmt (stale level) → the block stays in WAIT until tx_done is seen low then high, and sends no extra byte.

Source files
------------

// File: rtl/resp_tx_arbiter.sv
// Shares one UART transmitter between a high-priority 1-byte ack source and a
// low-priority multi-byte telemetry source with starvation protection.
module resp_tx_arbiter #(
    parameter int TLM_BYTES  = 8,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ack_req,
    input  logic [7:0]  ack_byte,
    output logic        ack_gnt,
    input  logic        tlm_req,
    input  logic [63:0] tlm_data,
    output logic        tlm_gnt,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic        owner
);

    localparam int SC_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    state_t          state, state_nxt;
    // Holds only the bytes still queued behind the one currently in tx_data.
    logic [55:0]     shift_q, shift_nxt;
    logic [3:0]      bytes_left, bytes_left_nxt;
    logic [SC_W-1:0] starve_cnt, starve_nxt;
    logic            seen_low, seen_low_nxt;
    logic            owner_q, owner_nxt;
    logic            trmt_nxt, ack_gnt_nxt, tlm_gnt_nxt;
    logic [7:0]      tx_data_nxt;
    logic            force_tlm;

    assign force_tlm = tlm_req && (starve_cnt == SC_W'(STARVE_LIM));
    assign busy      = (state != IDLE);
    assign owner     = busy & owner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_q    <= '0;
            bytes_left <= '0;
            starve_cnt <= '0;
            seen_low   <= 1'b0;
            owner_q    <= 1'b0;
            trmt       <= 1'b0;
            ack_gnt    <= 1'b0;
            tlm_gnt    <= 1'b0;
            tx_data    <= '0;
        end else begin
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            bytes_left <= bytes_left_nxt;
            starve_cnt <= starve_nxt;
            seen_low   <= seen_low_nxt;
            owner_q    <= owner_nxt;
            trmt       <= trmt_nxt;
            ack_gnt    <= ack_gnt_nxt;
            tlm_gnt    <= tlm_gnt_nxt;
            tx_data    <= tx_data_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift_q;
        bytes_left_nxt = bytes_left;
        starve_nxt     = starve_cnt;
        seen_low_nxt   = seen_low;
        owner_nxt      = owner_q;
        trmt_nxt       = 1'b0;
        ack_gnt_nxt    = 1'b0;
        tlm_gnt_nxt    = 1'b0;
        tx_data_nxt    = tx_data;

        case (state)
            IDLE: begin
                if (ack_req && !force_tlm) begin
                    tx_data_nxt    = ack_byte;
                    shift_nxt      = '0;
                    bytes_left_nxt = 4'd1;
                    owner_nxt      = 1'b0;
                    ack_gnt_nxt    = 1'b1;
                    trmt_nxt       = 1'b1;
                    state_nxt      = SEND;
                    if (!tlm_req)
                        starve_nxt = '0;
                    else if (starve_cnt != SC_W'(STARVE_LIM))
                        starve_nxt = starve_cnt + 1'b1;
                end else if (tlm_req) begin
                    tx_data_nxt    = tlm_data[63:56];
                    shift_nxt      = tlm_data[55:0];
                    bytes_left_nxt = 4'(TLM_BYTES);
                    owner_nxt      = 1'b1;
                    tlm_gnt_nxt    = 1'b1;
                    trmt_nxt       = 1'b1;
                    starve_nxt     = '0;
                    state_nxt      = SEND;
                end
            end
            SEND: begin
                seen_low_nxt = 1'b0;
                state_nxt    = WAIT;
            end
            WAIT: begin
                // A high tx_done only counts once it has been seen low since trmt.
                if (!seen_low) begin
                    if (!tx_done)
                        seen_low_nxt = 1'b1;
                end else if (tx_done) begin
                    if (bytes_left <= 4'd1) begin
                        state_nxt = IDLE;
                    end else begin
                        tx_data_nxt    = shift_q[55:48];
                        shift_nxt      = {shift_q[47:0], 8'h00};
                        bytes_left_nxt = bytes_left - 4'd1;
                        trmt_nxt       = 1'b1;
                        state_nxt      = SEND;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_resp_tx_arbiter.sv
// Directed bench for resp_tx_arbiter: byte-queue reference model compared every
// cycle, plus literal expectations on grant order and byte streams.
module tb_resp_tx_arbiter;

    localparam int TLM_BYTES  = 8;
    localparam int STARVE_LIM = 4;
    localparam int FRAME      = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ack_req = 1'b0;
    logic [7:0]  ack_byte = '0;
    logic        ack_gnt;
    logic        tlm_req = 1'b0;
    logic [63:0] tlm_data = '0;
    logic        tlm_gnt;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b1;
    logic        busy;
    logic        owner;

    int checks = 0;
    int failures = 0;

    resp_tx_arbiter #(
        .TLM_BYTES (TLM_BYTES),
        .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ack_req (ack_req),
        .ack_byte(ack_byte),
        .ack_gnt (ack_gnt),
        .tlm_req (tlm_req),
        .tlm_data(tlm_data),
        .tlm_gnt (tlm_gnt),
        .trmt    (trmt),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .busy    (busy),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // UART transmitter stand-in: tx_done drops the cycle after trmt, rises FRAME cycles later.
    bit uart_auto = 1'b1;
    bit upend = 1'b0;
    int ucnt = 0;
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            upend = 1'b0;
            ucnt = 0;
            if (uart_auto) tx_done = 1'b1;
        end else if (uart_auto) begin
            if (upend) begin
                tx_done = 1'b0;
                ucnt = FRAME;
                upend = 1'b0;
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) tx_done = 1'b1;
            end
            if (trmt) upend = 1'b1;
        end
    end

    // Reference model: a packet is a queue of bytes; the front byte is the one on the wire.
    byte unsigned m_q[$];
    bit       m_busy = 0, m_owner = 0, m_trmt = 0, m_gack = 0, m_gtlm = 0, m_armed = 0;
    bit [7:0] m_txd = '0;
    int       m_starve = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_busy = 0; m_owner = 0; m_trmt = 0; m_gack = 0; m_gtlm = 0;
            m_armed = 0; m_txd = '0; m_starve = 0;
        end else begin
            m_gack = 0;
            m_gtlm = 0;
            if (!m_busy) begin
                m_trmt = 0;
                if (ack_req && !(tlm_req && m_starve == STARVE_LIM)) begin
                    m_q.delete();
                    m_q.push_back(ack_byte);
                    m_owner = 0; m_gack = 1;
                    m_starve = tlm_req ? ((m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM) : 0;
                end else if (tlm_req) begin
                    m_q.delete();
                    for (int unsigned i = 0; i < TLM_BYTES; i++)
                        m_q.push_back(tlm_data[63 - 8*i -: 8]);
                    m_owner = 1; m_gtlm = 1; m_starve = 0;
                end
                if (m_gack || m_gtlm) begin
                    m_busy = 1; m_trmt = 1; m_txd = m_q[0];
                end
            end else if (m_trmt) begin
                m_trmt = 0;
                m_armed = 0;
            end else if (!m_armed) begin
                m_armed = !tx_done;
            end else if (tx_done) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_busy = 0;
                end else begin
                    m_trmt = 1;
                    m_txd = m_q[0];
                end
            end
        end
    end

    byte unsigned sent[$];
    bit           glog[$];   // 0 = ack grant, 1 = telemetry grant

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ack_gnt", ack_gnt, m_gack);
            chk("tlm_gnt", tlm_gnt, m_gtlm);
            chk("trmt", trmt, m_trmt);
            chk("busy", busy, m_busy);
            if (m_busy) begin
                chk("owner", owner, m_owner);
                chk("tx_data", tx_data, m_txd);
            end
            if (trmt) sent.push_back(tx_data);
            if (ack_gnt) glog.push_back(1'b0);
            if (tlm_gnt) glog.push_back(1'b1);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit tlm, input string name);
        bit got = 0;
        for (int unsigned i = 0; i < 300; i++) begin
            tick();
            if (tlm ? tlm_gnt : ack_gnt) begin
                got = 1;
                break;
            end
        end
        if (!got) timeout_fail(name);
    endtask

    task automatic wait_sent(input int n, input string name);
        bit got = 0;
        for (int unsigned i = 0; i < 300; i++) begin
            if (sent.size() >= n) begin
                got = 1;
                break;
            end
            tick();
        end
        if (!got) timeout_fail(name);
    endtask

    task automatic wait_idle(input string name);
        bit got = 0;
        for (int unsigned i = 0; i < 500; i++) begin
            tick();
            if (!busy) begin
                got = 1;
                break;
            end
        end
        if (!got) timeout_fail(name);
        tick();
    endtask

    initial begin
        int base;
        int gbase;

        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gbase;
        int c0;
        int g0;

        // Reset state
        repeat (3) tick();
        chk("rst_trmt", trmt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_gnts", {ack_gnt, tlm_gnt}, 2'b00);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single ack byte
        ack_byte = 8'hA5;
        ack_req = 1'b1;
        tick();
        chk("ack1_gnt", ack_gnt, 1);
        chk("ack1_trmt", trmt, 1);
        chk("ack1_tx_data", tx_data, 8'hA5);
        ack_req = 1'b0;
        wait_idle("ack1_idle");
        chk("ack1_busy_end", busy, 0);
        chk("ack1_trmt_count", sent.size(), 1);

        // Full telemetry packet
        base = sent.size();
        gbase = glog.size();
        tlm_data = 64'h0102030405060708;
        tlm_req = 1'b1;
        wait_gnt(1'b1, "tlm1_gnt");
        chk("tlm1_owner", owner, 1);
        tlm_req = 1'b0;
        tlm_data = 64'hDEADBEEFDEADBEEF;
        wait_idle("tlm1_idle");
        chk("tlm1_trmt_count", sent.size() - base, 8);
        chk("tlm1_gnt_count", glog.size() - gbase, 1);
        for (int unsigned i = 0; i < 8; i++)
            if (base + i < sent.size())
                chk("tlm1_byte", sent[base + i], i + 1);

        // Ack arriving during byte 3 waits for the packet to finish
        base = sent.size();
        tlm_data = 64'h0102030405060708;
        tlm_req = 1'b1;
        wait_gnt(1'b1, "pre_tlm_gnt");
        tlm_req = 1'b0;
        wait_sent(base + 3, "pre_byte3");
        ack_byte = 8'h3C;
        ack_req = 1'b1;
        wait_gnt(1'b0, "pre_ack_gnt");
        ack_req = 1'b0;
        wait_idle("pre_idle");
        chk("pre_count", sent.size() - base, 9);
        if (sent.size() >= base + 9) begin
            chk("pre_byte8", sent[base + 7], 8'h08);
            chk("pre_ack_9th", sent[base + 8], 8'h3C);
        end

        // Both requests held: ack x4, tlm, repeating
        gbase = glog.size();
        tlm_data = 64'hA1A2A3A4A5A6A7A8;
        ack_byte = 8'h55;
        tlm_req = 1'b1;
        ack_req = 1'b1;
        begin
            bit got = 0;
            for (int unsigned i = 0; i < 3000; i++) begin
                tick();
                if (glog.size() >= gbase + 10) begin
                    got = 1;
                    break;
                end
            end
            if (!got) timeout_fail("starve_grants");
        end
        tlm_req = 1'b0;
        ack_req = 1'b0;
        wait_idle("starve_idle");
        for (int unsigned i = 0; i < 10; i++)
            if (gbase + i < glog.size())
                chk("starve_order", glog[gbase + i], (i % 5 == 4) ? 1 : 0);

        // Stale tx_done: held high from before trmt
        uart_auto = 1'b0;
        tx_done = 1'b1;
        base = sent.size();
        ack_byte = 8'h77;
        ack_req = 1'b1;
        wait_gnt(1'b0, "stale_gnt");
        ack_req = 1'b0;
        repeat (10) tick();
        chk("stale_busy_hold", busy, 1);
        chk("stale_trmt_count", sent.size() - base, 1);
        tx_done = 1'b0;
        repeat (2) tick();
        tx_done = 1'b1;
        repeat (3) tick();
        chk("stale_busy_end", busy, 0);
        chk("stale_trmt_final", sent.size() - base, 1);
        uart_auto = 1'b1;
        repeat (2) tick();

        // Asynchronous reset during byte 5
        base = sent.size();
        tlm_data = 64'h1112131415161718;
        tlm_req = 1'b1;
        wait_gnt(1'b1, "rst_tlm_gnt");
        tlm_req = 1'b0;
        wait_sent(base + 5, "rst_byte5");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_trmt", trmt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_owner", owner, 0);
        chk("arst_tx_data", tx_data, 8'h00);
        repeat (3) tick();
        rst_n = 1'b1;
        c0 = sent.size();
        g0 = glog.size();
        repeat (100) tick();
        chk("post_rst_no_trmt", sent.size() - c0, 0);
        chk("post_rst_no_gnt", glog.size() - g0, 0);
        chk("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
